// File: rtl/stepper_axis_ctrl.sv
// stepper_axis_ctrl
//
// Single-axis stepper positioner. Homes against the left end switch,
// measures the rail span by stepping to the right switch, parks at mid-span,
// then tracks a clamped commanded target. It produces the step/dir pins for
// the motor driver and exports position and state for the debug display.
//
// Ports
//   clock, reset      system clock and synchronous active-high reset
//   calib             one-cycle pulse: (re)start calibration from any state
//   hold              level: while high, TRACK starts no new step slots
//   target            requested position in steps from the left end
//   target_load       one-cycle strobe capturing target (clamped), TRACK only
//   end_left/right    asynchronous active-high limit switches
//   step, dir         driver pins; dir=1 moves right (position increments)
//   current_pos       step count from the left end
//   span              measured left-to-right travel
//   ready             calibrated and in TRACK
//   at_target         in TRACK, current_pos == tgt and no slot in progress
//   fault             in FAULT
//   db_estado         state code (IDLE=0 .. FAULT=5)
//
// Motion is organised in step slots of 2*STEP_HALF cycles: c=0 sets dir with
// step low, c=1..STEP_HALF drives step high, the rest is low. Slots run
// back-to-back while motion is needed. STEP_HALF must be at least 2.

module stepper_axis_ctrl #(
  parameter int POS_W     = 16,
  parameter int STEP_HALF = 25000,
  parameter int MARGIN    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             calib,
  input  logic             hold,
  input  logic [POS_W-1:0] target,
  input  logic             target_load,
  input  logic             end_left,
  input  logic             end_right,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] current_pos,
  output logic [POS_W-1:0] span,
  output logic             ready,
  output logic             at_target,
  output logic             fault,
  output logic [2:0]       db_estado
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HOME_LEFT  = 3'd1,
    ST_SEEK_RIGHT = 3'd2,
    ST_CENTER     = 3'd3,
    ST_TRACK      = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  localparam int SLOT_LEN = 2 * STEP_HALF;
  localparam int CNT_W    = $clog2(SLOT_LEN);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] STEP_HI   = CNT_W'(STEP_HALF);
  localparam logic [POS_W-1:0] POS_MAX   = '1;
  localparam logic [POS_W:0]   MARGIN_W  = (POS_W + 1)'(MARGIN);
  localparam logic [POS_W:0]   MARGIN2_W = (POS_W + 1)'(2 * MARGIN);

  // ---------------------------------------------------------------------
  // Limit switch synchronisers: bit 0 = left, bit 1 = right.
  // ---------------------------------------------------------------------
  logic [1:0] sw_raw;
  logic [1:0] sw_sync;

  assign sw_raw = {end_right, end_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= sw_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sw_sync[gi] = sync_reg;
    end
  endgenerate

  logic left_sync;
  logic right_sync;
  assign left_sync  = sw_sync[0];
  assign right_sync = sw_sync[1];

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t             state_reg;
  logic               slot_active_reg;
  logic [CNT_W-1:0]   slot_cnt_reg;
  logic               step_reg;
  logic               dir_reg;
  logic [POS_W-1:0]   pos_reg;
  logic [POS_W-1:0]   span_reg;
  logic [POS_W-1:0]   tgt_reg;
  logic [POS_W-1:0]   home_cnt_reg;
  logic               ready_reg;
  logic               at_target_reg;
  logic               fault_reg;
  // A switch only counts as a limit violation once it has been seen low.
  // The carriage leaves CENTER sitting on the right switch it just found,
  // so that switch is disarmed until it releases.
  logic               left_armed_reg;
  logic               right_armed_reg;

  // Target clamp into [MARGIN, span-MARGIN]; a rail too short for the
  // margins parks at mid-span instead.
  function automatic logic [POS_W-1:0] clamp_target(
    input logic [POS_W-1:0] t,
    input logic [POS_W-1:0] s
  );
    logic [POS_W:0] t_w;
    logic [POS_W:0] s_w;
    logic [POS_W:0] hi_w;
    logic [POS_W-1:0] res;
    t_w  = {1'b0, t};
    s_w  = {1'b0, s};
    hi_w = s_w - MARGIN_W;
    if (s_w < MARGIN2_W) begin
      res = s >> 1;
    end else if (t_w < MARGIN_W) begin
      res = MARGIN_W[POS_W-1:0];
    end else if (t_w > hi_w) begin
      res = hi_w[POS_W-1:0];
    end else begin
      res = t;
    end
    return res;
  endfunction

  logic             slot_end;
  logic             decide;
  logic             limit_hit;
  logic             load_ok;
  logic             pos_tick;
  logic             counting;
  logic [POS_W-1:0] clamped;
  logic [POS_W-1:0] tgt_eff;

  // Decisions are taken on the last cycle of a slot or whenever idle.
  assign slot_end  = slot_active_reg && (slot_cnt_reg == SLOT_LAST);
  assign decide    = !slot_active_reg || slot_end;
  assign limit_hit = ((state_reg == ST_CENTER) || (state_reg == ST_TRACK)) &&
                     ((left_sync && left_armed_reg) || (right_sync && right_armed_reg));
  // calib outranks a load issued in the same cycle.
  assign load_ok   = target_load && (state_reg == ST_TRACK) && !calib && !limit_hit;
  assign clamped   = clamp_target(target, span_reg);
  // A load arriving exactly on a boundary steers that boundary's decision.
  assign tgt_eff   = load_ok ? clamped : tgt_reg;
  assign counting  = (state_reg == ST_SEEK_RIGHT) || (state_reg == ST_CENTER) ||
                     (state_reg == ST_TRACK);
  // Position moves in the cycle step rises (c=1), i.e. on the c=0 -> c=1 edge,
  // unless the slot is being aborted.
  assign pos_tick  = slot_active_reg && (slot_cnt_reg == '0) && counting &&
                     !calib && !limit_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      slot_active_reg <= 1'b0;
      slot_cnt_reg    <= '0;
      step_reg        <= 1'b0;
      dir_reg         <= 1'b0;
      pos_reg         <= '0;
      span_reg        <= '0;
      tgt_reg         <= '0;
      home_cnt_reg    <= '0;
      ready_reg       <= 1'b0;
      at_target_reg   <= 1'b0;
      fault_reg       <= 1'b0;
      left_armed_reg  <= 1'b0;
      right_armed_reg <= 1'b0;
    end else begin
      at_target_reg <= 1'b0;
      if (!left_sync)  left_armed_reg  <= 1'b1;
      if (!right_sync) right_armed_reg <= 1'b1;

      // Advance through the current slot.
      if (slot_active_reg && !slot_end) begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
        step_reg     <= ((slot_cnt_reg + 1'b1) <= STEP_HI);
      end

      if (pos_tick) begin
        pos_reg <= dir_reg ? pos_reg + 1'b1 : pos_reg - 1'b1;
      end

      if (load_ok) begin
        tgt_reg <= clamped;
      end

      if (calib) begin
        // Abort whatever is running and begin the first homing slot now.
        state_reg       <= ST_HOME_LEFT;
        ready_reg       <= 1'b0;
        fault_reg       <= 1'b0;
        home_cnt_reg    <= POS_W'(1);
        slot_active_reg <= 1'b1;
        slot_cnt_reg    <= '0;
        step_reg        <= 1'b0;
        dir_reg         <= 1'b0;
      end else if (limit_hit) begin
        state_reg       <= ST_FAULT;
        fault_reg       <= 1'b1;
        ready_reg       <= 1'b0;
        slot_active_reg <= 1'b0;
        slot_cnt_reg    <= '0;
        step_reg        <= 1'b0;
      end else if (decide) begin
        // Default: stop; branches that continue moving start a new slot.
        slot_active_reg <= 1'b0;
        slot_cnt_reg    <= '0;
        step_reg        <= 1'b0;
        case (state_reg)
          ST_IDLE: begin
          end

          ST_HOME_LEFT: begin
            if (left_sync) begin
              pos_reg         <= '0;
              state_reg       <= ST_SEEK_RIGHT;
              left_armed_reg  <= 1'b0;
              slot_active_reg <= 1'b1;
              dir_reg         <= 1'b1;
            end else if (home_cnt_reg == POS_MAX) begin
              state_reg <= ST_FAULT;
              fault_reg <= 1'b1;
            end else begin
              home_cnt_reg    <= home_cnt_reg + 1'b1;
              slot_active_reg <= 1'b1;
              dir_reg         <= 1'b0;
            end
          end

          ST_SEEK_RIGHT: begin
            if (right_sync) begin
              span_reg        <= pos_reg;
              tgt_reg         <= pos_reg >> 1;
              state_reg       <= ST_CENTER;
              right_armed_reg <= 1'b0;
              // Mid-span is always at or left of the right end.
              if (pos_reg != (pos_reg >> 1)) begin
                slot_active_reg <= 1'b1;
                dir_reg         <= 1'b0;
              end
            end else if (pos_reg == POS_MAX) begin
              state_reg <= ST_FAULT;
              fault_reg <= 1'b1;
            end else begin
              slot_active_reg <= 1'b1;
              dir_reg         <= 1'b1;
            end
          end

          ST_CENTER: begin
            if (pos_reg == tgt_reg) begin
              state_reg     <= ST_TRACK;
              ready_reg     <= 1'b1;
              at_target_reg <= 1'b1;
            end else begin
              slot_active_reg <= 1'b1;
              dir_reg         <= (tgt_reg > pos_reg);
            end
          end

          ST_TRACK: begin
            if (!hold && (pos_reg != tgt_eff)) begin
              slot_active_reg <= 1'b1;
              dir_reg         <= (tgt_eff > pos_reg);
            end else begin
              at_target_reg <= (pos_reg == tgt_eff);
            end
          end

          ST_FAULT: begin
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign step        = step_reg;
  assign dir         = dir_reg;
  assign current_pos = pos_reg;
  assign span        = span_reg;
  assign ready       = ready_reg;
  assign at_target   = at_target_reg;
  assign fault       = fault_reg;
  assign db_estado   = state_reg;

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Bench for stepper_axis_ctrl with POS_W=8, STEP_HALF=2, MARGIN=2.
// A rail model follows the step/dir pins and drives the end switches
// (left at <=0, right at >=40, carriage initially at 17). Stimulus pushes
// the expected snapshot for each anticipated DUT event (HOME_LEFT entry,
// at_target rise, fault rise) into a queue; a monitor pops on each event.

module tb_stepper_axis_ctrl;

  localparam int POS_W = 8;
  localparam int EV_HOME = 0;
  localparam int EV_ARR  = 1;
  localparam int EV_FLT  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             calib;
  logic             hold;
  logic [POS_W-1:0] target;
  logic             target_load;
  logic             end_left;
  logic             end_right;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] current_pos;
  logic [POS_W-1:0] span;
  logic             ready;
  logic             at_target;
  logic             fault;
  logic [2:0]       db_estado;

  stepper_axis_ctrl #(.POS_W(POS_W), .STEP_HALF(2), .MARGIN(2)) dut (
    .clock(clock), .reset(reset), .calib(calib), .hold(hold),
    .target(target), .target_load(target_load),
    .end_left(end_left), .end_right(end_right),
    .step(step), .dir(dir), .current_pos(current_pos), .span(span),
    .ready(ready), .at_target(at_target), .fault(fault), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // ---------------- rail model ----------------
  int   model_pos   = 17;
  bit   right_conn  = 1'b1;
  bit   force_right = 1'b0;
  bit   mstep_q     = 1'b0;

  assign end_left  = (model_pos <= 0);
  assign end_right = (right_conn && model_pos >= 40) || force_right;

  always @(negedge clock) begin
    if (step === 1'b1 && !mstep_q) model_pos += (dir ? 1 : -1);
    mstep_q = (step === 1'b1);
  end

  // ---------------- step waveform checker ----------------
  int cyc_n     = 0;
  int last_rise = -1;
  int hi_len    = 0;
  int step_err  = 0;
  int rise_cnt  = 0;
  bit step_q    = 1'b0;
  bit dir_q     = 1'b0;
  bit reset_q   = 1'b1;

  always @(negedge clock) begin
    cyc_n++;
    if (reset || reset_q) begin
      last_rise = -1;
      hi_len    = 0;
      step_q    = 1'b0;
    end else begin
      if (step && !step_q) begin
        rise_cnt++;
        if (last_rise >= 0 && (cyc_n - last_rise) < 4) step_err++;
        last_rise = cyc_n;
        hi_len    = 1;
      end else if (step) begin
        hi_len++;
      end
      if (!step && step_q && hi_len != 2) step_err++;
      if (step && (dir != dir_q)) step_err++;
      step_q = step;
    end
    dir_q   = dir;
    reset_q = reset;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string name;
    int    kind;
    int    pos;
    int    spn;
    int    rdy;
    int    at_t;
    int    flt;
    int    st;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input string name, input int kind, input int pos, input int spn,
                          input int rdy, input int at_t, input int flt, input int st);
    exp_t e;
    e.name = name; e.kind = kind; e.pos = pos; e.spn = spn;
    e.rdy = rdy; e.at_t = at_t; e.flt = flt; e.st = st;
    sb_q.push_back(e);
  endtask

  task automatic handle_event(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_event: kind %0d state %0d pos %0d", kind, db_estado, current_pos);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "/kind"},  kind, e.kind);
      check({e.name, "/state"}, int'(db_estado), e.st);
      check({e.name, "/ready"}, int'(ready), e.rdy);
      check({e.name, "/fault"}, int'(fault), e.flt);
      check({e.name, "/at_target"}, int'(at_target), e.at_t);
      check({e.name, "/step"},  int'(step), 0);
      if (e.kind != EV_HOME) begin
        check({e.name, "/pos"},  int'(current_pos), e.pos);
        check({e.name, "/span"}, int'(span), e.spn);
      end
    end
  endtask

  logic [2:0] db_q  = 3'd0;
  logic       at_q  = 1'b0;
  logic       flt_q = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (db_estado == 3'd1 && db_q != 3'd1) handle_event(EV_HOME);
      if (at_target && !at_q)                handle_event(EV_ARR);
      if (fault && !flt_q)                   handle_event(EV_FLT);
    end
    db_q  = db_estado;
    at_q  = at_target;
    flt_q = fault;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: timeout, %0d events pending after %0d cycles", tag, sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic pulse_calib();
    calib = 1'b1;
    cyc(1);
    calib = 1'b0;
  endtask

  task automatic load_target(input int t);
    target      = POS_W'(t);
    target_load = 1'b1;
    cyc(1);
    target_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/step"},      int'(step), 0);
    check({tag, "/dir"},       int'(dir), 0);
    check({tag, "/pos"},       int'(current_pos), 0);
    check({tag, "/span"},      int'(span), 0);
    check({tag, "/ready"},     int'(ready), 0);
    check({tag, "/at_target"}, int'(at_target), 0);
    check({tag, "/fault"},     int'(fault), 0);
    check({tag, "/state"},     int'(db_estado), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int lat;
    reset = 1'b1; calib = 1'b0; hold = 1'b0; target = '0; target_load = 1'b0;
    cyc(3);
    check_reset_outputs("reset_initial");
    reset = 1'b0;
    cyc(2);

    // Calibration: span 40, park at 20.
    push_exp("cal1_home", EV_HOME, 0, 0, 0, 0, 0, 1);
    push_exp("cal1_park", EV_ARR, 20, 40, 1, 1, 0, 4);
    pulse_calib();
    wait_drain(3000, "cal1");

    // Tracking with clamping.
    push_exp("trk_50", EV_ARR, 38, 40, 1, 1, 0, 4);
    load_target(50);
    wait_drain(500, "trk_50");
    push_exp("trk_0", EV_ARR, 2, 40, 1, 1, 0, 4);
    load_target(0);
    wait_drain(500, "trk_0");

    // Hold blocks new slots.
    hold = 1'b1;
    cyc(1);
    r0 = rise_cnt;
    load_target(25);
    cyc(20);
    check("hold_no_steps", rise_cnt - r0, 0);
    check("hold_pos", int'(current_pos), 2);
    check("hold_at_target", int'(at_target), 0);
    push_exp("trk_25", EV_ARR, 25, 40, 1, 1, 0, 4);
    hold = 1'b0;
    wait_drain(500, "trk_25");

    // Limit violation at 30.
    push_exp("trk_30", EV_ARR, 30, 40, 1, 1, 0, 4);
    load_target(30);
    wait_drain(200, "trk_30");
    push_exp("limit_fault", EV_FLT, 30, 40, 0, 0, 1, 5);
    force_right = 1'b1;
    lat = 0;
    while (!fault && lat < 3) begin
      cyc(1);
      lat++;
    end
    check("fault_within_3", int'(fault), 1);
    check("fault_state", int'(db_estado), 5);
    check("fault_step", int'(step), 0);
    wait_drain(20, "limit_fault");
    r0 = rise_cnt;
    load_target(10);
    cyc(20);
    check("fault_load_pos", int'(current_pos), 30);
    check("fault_load_state", int'(db_estado), 5);
    check("fault_load_steps", rise_cnt - r0, 0);
    force_right = 1'b0;
    push_exp("cal2_home", EV_HOME, 0, 0, 0, 0, 0, 1);
    push_exp("cal2_park", EV_ARR, 20, 40, 1, 1, 0, 4);
    pulse_calib();
    wait_drain(3000, "cal2");

    // calib together with target_load in TRACK.
    push_exp("cal3_home", EV_HOME, 0, 0, 0, 0, 0, 1);
    target      = 8'd35;
    target_load = 1'b1;
    calib       = 1'b1;
    cyc(1);
    target_load = 1'b0;
    calib       = 1'b0;
    cyc(3);
    check("cal3_ready", int'(ready), 0);
    check("cal3_state", int'(db_estado), 1);
    push_exp("cal3_park", EV_ARR, 20, 40, 1, 1, 0, 4);
    wait_drain(3000, "cal3");

    // Right switch disconnected: runaway ends at position 255.
    right_conn = 1'b0;
    push_exp("run_home", EV_HOME, 0, 0, 0, 0, 0, 1);
    push_exp("run_fault", EV_FLT, 255, 40, 0, 0, 1, 5);
    pulse_calib();
    wait_drain(4000, "runaway");
    right_conn = 1'b1;

    // Reset in the middle of homing.
    push_exp("cal4_home", EV_HOME, 0, 0, 0, 0, 0, 1);
    pulse_calib();
    wait_drain(10, "cal4");
    cyc(6);
    reset = 1'b1;
    cyc(1);
    check_reset_outputs("reset_midrun");
    reset = 1'b0;
    cyc(3);

    check("step_waveform_errors", step_err, 0);
    check("step_rises_seen", int'(rise_cnt > 300), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
